// File: rtl/avl_cfg_pkg.sv
// Shared opcodes and FSM state encoding for the Avalon-MM configuration sequencer.
package avl_cfg_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_DELAY = 2'd2;
  localparam logic [1:0] OP_END   = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWr,
    StRd,
    StRdGap,
    StWait,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/avl_cfg_start_sync.sv
// Two-flop synchronizer for the asynchronous start request with rising-edge pulse output.
module avl_cfg_start_sync (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic start_pulse
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= start;
      sync_q2 <= sync_q1;
    end
  end

  assign start_pulse = sync_q1 & ~sync_q2;

endmodule

// File: rtl/avl_cfg_sequencer.sv
// Walks an external command table and issues Avalon-MM writes, masked read-polls and delays.
module avl_cfg_sequencer
  import avl_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 19,
  parameter int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned MAX_POLLS = 0,
  parameter int unsigned DLY_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [IDX_W-1:0]  tbl_index,
  input  logic [1:0]        tbl_op,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic [DATA_W-1:0] tbl_mask,
  output logic [ADDR_W-1:0] avl_address,
  output logic [DATA_W-1:0] avl_writedata,
  output logic              avl_read_req,
  output logic              avl_write_req,
  input  logic              avl_busy,
  input  logic [DATA_W-1:0] avl_readdata,
  output logic              running,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  err_index
);

  localparam int unsigned PC_W = (MAX_POLLS > 0) ? $clog2(MAX_POLLS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [PC_W-1:0]  POLL_LIM = PC_W'(MAX_POLLS);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [IDX_W-1:0]  err_index_q, err_index_d;
  logic [PC_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic              start_pulse;
  logic              match;
  logic              advance;

  avl_cfg_start_sync u_start_sync (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_pulse (start_pulse)
  );

  assign match = ((avl_readdata ^ tbl_data) & tbl_mask) == '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      index_q     <= '0;
      err_index_q <= '0;
      poll_cnt_q  <= '0;
      dly_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      err_index_q <= err_index_d;
      poll_cnt_q  <= poll_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    err_index_d = err_index_q;
    poll_cnt_d  = poll_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    advance     = 1'b0;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_pulse) begin
          index_d     = '0;
          err_index_d = '0;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        unique case (tbl_op)
          OP_WRITE: state_d = StWr;
          OP_POLL: begin
            poll_cnt_d = PC_W'(1);
            state_d    = StRd;
          end
          OP_DELAY: begin
            dly_cnt_d = tbl_data[DLY_W-1:0];
            state_d   = StWait;
          end
          OP_END:   state_d = StDone;
        endcase
      end
      StWr: begin
        if (!avl_busy) advance = 1'b1;
      end
      StRd: begin
        if (!avl_busy) begin
          if (match) begin
            advance = 1'b1;
          end else if ((MAX_POLLS != 0) && (poll_cnt_q == POLL_LIM)) begin
            err_index_d = index_q;
            state_d     = StErr;
          end else begin
            state_d = StRdGap;
          end
        end
      end
      // Gap cycle keeps read_req low for at least one cycle between polls.
      StRdGap: begin
        poll_cnt_d = poll_cnt_q + PC_W'(1);
        state_d    = StRd;
      end
      StWait: begin
        if (dly_cnt_q == '0) begin
          advance = 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q - DLY_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (index_q == LAST_IDX) begin
        state_d = StDone;
      end else begin
        index_d = index_q + IDX_W'(1);
        state_d = StFetch;
      end
    end
  end

  always_comb begin
    avl_write_req = (state_q == StWr);
    avl_read_req  = (state_q == StRd);
    done          = (state_q == StDone);
    error         = (state_q == StErr);
    running       = (state_q == StFetch) || (state_q == StWr) || (state_q == StRd) ||
                    (state_q == StRdGap) || (state_q == StWait);
  end

  assign tbl_index     = index_q;
  assign err_index     = err_index_q;
  assign avl_address   = tbl_addr;
  assign avl_writedata = tbl_data;

endmodule

// File: tb/tb_avl_cfg_sequencer.sv
// Directed bench for avl_cfg_sequencer: table, bus responder and monitor live here.
module tb_avl_cfg_sequencer;
  import avl_cfg_pkg::*;

  localparam int unsigned IDX_W = 3;

  logic              clock;
  logic              reset;
  logic              start;
  logic [IDX_W-1:0]  tbl_index;
  logic [1:0]        tbl_op;
  logic [7:0]        tbl_addr;
  logic [31:0]       tbl_data;
  logic [31:0]       tbl_mask;
  logic [7:0]        avl_address;
  logic [31:0]       avl_writedata;
  logic              avl_read_req;
  logic              avl_write_req;
  logic              avl_busy;
  logic [31:0]       avl_readdata;
  logic              running;
  logic              done;
  logic              error;
  logic [IDX_W-1:0]  err_index;

  logic [1:0]  op_t   [8];
  logic [7:0]  addr_t [8];
  logic [31:0] data_t [8];
  logic [31:0] mask_t [8];
  logic [31:0] rd_data [32];

  int tests = 0;
  int fails = 0;
  int busy_target;

  // Responder state (written only by the posedge block)
  int cyc = 0;
  int busy_spent = 0;
  int rd_ptr = 0;

  // Monitor state (written only by the negedge block)
  int wr_cycles = 0, wr_done = 0, rd_done = 0, rd_rise = 0, both_high = 0;
  int wr_unstable = 0, run_rise = 0, t_run = 0, t_done = 0, t_wr_rise = 0;
  logic [7:0]  wr_addr_log [16];
  logic [31:0] wr_data_log [16];
  logic        wr_prev = 1'b0, rd_prev = 1'b0, run_prev = 1'b0, done_prev = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;

  avl_cfg_sequencer #(
    .ADDR_W    (8),
    .DATA_W    (32),
    .DEPTH     (8),
    .MAX_POLLS (3),
    .DLY_W     (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .tbl_index     (tbl_index),
    .tbl_op        (tbl_op),
    .tbl_addr      (tbl_addr),
    .tbl_data      (tbl_data),
    .tbl_mask      (tbl_mask),
    .avl_address   (avl_address),
    .avl_writedata (avl_writedata),
    .avl_read_req  (avl_read_req),
    .avl_write_req (avl_write_req),
    .avl_busy      (avl_busy),
    .avl_readdata  (avl_readdata),
    .running       (running),
    .done          (done),
    .error         (error),
    .err_index     (err_index)
  );

  assign tbl_op       = op_t[tbl_index];
  assign tbl_addr     = addr_t[tbl_index];
  assign tbl_data     = data_t[tbl_index];
  assign tbl_mask     = mask_t[tbl_index];
  assign avl_busy     = (avl_read_req | avl_write_req) && (busy_spent < busy_target);
  assign avl_readdata = rd_data[rd_ptr % 32];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if ((avl_read_req | avl_write_req) && avl_busy) busy_spent <= busy_spent + 1;
    if (avl_read_req && !avl_busy) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clock) begin
    if (avl_write_req) wr_cycles <= wr_cycles + 1;
    if (avl_write_req && !avl_busy) begin
      wr_addr_log[wr_done % 16] <= avl_address;
      wr_data_log[wr_done % 16] <= avl_writedata;
      wr_done <= wr_done + 1;
    end
    if (avl_write_req && wr_prev && (avl_address != prev_addr || avl_writedata != prev_data))
      wr_unstable <= wr_unstable + 1;
    if (avl_write_req && !wr_prev) t_wr_rise <= cyc;
    if (avl_read_req && !avl_busy) rd_done <= rd_done + 1;
    if (avl_read_req && !rd_prev) rd_rise <= rd_rise + 1;
    if (avl_read_req && avl_write_req) both_high <= both_high + 1;
    if (running && !run_prev) begin
      run_rise <= run_rise + 1;
      t_run    <= cyc;
    end
    if (done && !done_prev) t_done <= cyc;
    wr_prev   <= avl_write_req;
    rd_prev   <= avl_read_req;
    run_prev  <= running;
    done_prev <= done;
    prev_addr <= avl_address;
    prev_data <= avl_writedata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_all_write();
    for (int i = 0; i < 8; i++) begin
      op_t[i]   = OP_WRITE;
      addr_t[i] = 8'h10 + 8'(i);
      data_t[i] = 32'hA500_0000 + 32'(i);
      mask_t[i] = '0;
    end
  endtask

  task automatic start_run(input bit hold);
    int n;
    n = 0;
    start = 1'b1;
    while (!running && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("start_accept", 32'(running), 32'd1);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_fin(input string tag, input int budget);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk(tag, 32'(done | error), 32'd1);
  endtask

  int b_wr, b_wrc, b_rd, b_rise, b_unst, b_run, n;

  initial begin
    busy_target = 0;
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) rd_data[i] = '0;
    set_all_write();
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_index", 32'(tbl_index), 32'd0);
    chk("rst_reqs", 32'({avl_read_req, avl_write_req}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Eight back-to-back writes, busy low: 2 cycles per entry
    b_wr = wr_done; b_wrc = wr_cycles;
    start_run(1'b0);
    wait_fin("all_write_fin", 100);
    chk("all_write_count", 32'(wr_done - b_wr), 32'd8);
    chk("all_write_cycles", 32'(wr_cycles - b_wrc), 32'd8);
    chk("all_write_addr0", 32'(wr_addr_log[b_wr % 16]), 32'h10);
    chk("all_write_addr7", 32'(wr_addr_log[(b_wr + 7) % 16]), 32'h17);
    chk("all_write_data3", wr_data_log[(b_wr + 3) % 16], 32'hA500_0003);
    chk("all_write_latency", 32'(t_done - t_run), 32'd16);
    chk("all_write_running", 32'(running), 32'd0);
    chk("all_write_index", 32'(tbl_index), 32'd7);

    // Write stalled by 3 busy cycles
    op_t[0] = OP_WRITE; addr_t[0] = 8'h40; data_t[0] = 32'hDEAD_BEEF;
    op_t[1] = OP_END;
    b_wr = wr_done; b_wrc = wr_cycles; b_unst = wr_unstable;
    busy_target = busy_spent + 3;
    start_run(1'b0);
    wait_fin("busy_write_fin", 100);
    chk("busy_write_cycles", 32'(wr_cycles - b_wrc), 32'd4);
    chk("busy_write_count", 32'(wr_done - b_wr), 32'd1);
    chk("busy_write_stable", 32'(wr_unstable - b_unst), 32'd0);
    chk("busy_write_addr", 32'(wr_addr_log[b_wr % 16]), 32'h40);
    chk("busy_write_index", 32'(tbl_index), 32'd1);
    chk("busy_write_done", 32'(done), 32'd1);

    // Poll matching on the third (last permitted) read
    op_t[0] = OP_POLL; addr_t[0] = 8'h20; data_t[0] = 32'h1; mask_t[0] = 32'h1;
    rd_data[rd_ptr % 32]       = 32'h0;
    rd_data[(rd_ptr + 1) % 32] = 32'h0;
    rd_data[(rd_ptr + 2) % 32] = 32'hFFFF_FFF1;
    b_rd = rd_done; b_rise = rd_rise;
    start_run(1'b0);
    wait_fin("poll_fin", 100);
    chk("poll_reads", 32'(rd_done - b_rd), 32'd3);
    chk("poll_read_edges", 32'(rd_rise - b_rise), 32'd3);
    chk("poll_no_error", 32'(error), 32'd0);
    chk("poll_done", 32'(done), 32'd1);
    chk("poll_index", 32'(tbl_index), 32'd1);

    // Poll at index 5 that never matches
    set_all_write();
    op_t[5] = OP_POLL; data_t[5] = 32'h55; mask_t[5] = 32'hFF;
    rd_data[rd_ptr % 32]       = 32'h0;
    rd_data[(rd_ptr + 1) % 32] = 32'hAA;
    rd_data[(rd_ptr + 2) % 32] = 32'h54;
    rd_data[(rd_ptr + 3) % 32] = 32'h55;
    b_rd = rd_done; b_wr = wr_done;
    start_run(1'b0);
    wait_fin("poll_err_fin", 100);
    chk("poll_err_reads", 32'(rd_done - b_rd), 32'd3);
    chk("poll_err_writes", 32'(wr_done - b_wr), 32'd5);
    chk("poll_err_error", 32'(error), 32'd1);
    chk("poll_err_index", 32'(err_index), 32'd5);
    chk("poll_err_done", 32'(done), 32'd0);
    chk("poll_err_running", 32'(running), 32'd0);

    // Restart clears error and reruns from index 0
    set_all_write();
    b_wr = wr_done;
    start_run(1'b0);
    chk("restart_error_clr", 32'(error), 32'd0);
    chk("restart_erridx_clr", 32'(err_index), 32'd0);
    chk("restart_index", 32'(tbl_index), 32'd0);
    wait_fin("restart_fin", 100);
    chk("restart_done", 32'(done), 32'd1);
    chk("restart_writes", 32'(wr_done - b_wr), 32'd8);

    // Delay of 10 then a write, END at index 2
    set_all_write();
    op_t[0] = OP_DELAY; data_t[0] = 32'h1234_000A;
    op_t[1] = OP_WRITE; addr_t[1] = 8'h33;
    op_t[2] = OP_END;
    b_wr = wr_done; b_rd = rd_done;
    start_run(1'b0);
    wait_fin("delay_fin", 100);
    chk("delay_latency", 32'(t_wr_rise - t_run), 32'd13);
    chk("delay_writes", 32'(wr_done - b_wr), 32'd1);
    chk("delay_write_addr", 32'(wr_addr_log[b_wr % 16]), 32'h33);
    chk("end_no_reads", 32'(rd_done - b_rd), 32'd0);
    chk("end_index", 32'(tbl_index), 32'd2);
    chk("end_done", 32'(done), 32'd1);

    // Reset while a read is stalled
    set_all_write();
    op_t[2] = OP_POLL; data_t[2] = 32'h0; mask_t[2] = 32'hFFFF_FFFF;
    start_run(1'b0);
    n = 0;
    while (!avl_read_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("abort_read_seen", 32'(avl_read_req), 32'd1);
    busy_target = busy_spent + 100;
    repeat (2) @(negedge clock);
    chk("abort_read_held", 32'(avl_read_req), 32'd1);
    chk("abort_index_pre", 32'(tbl_index), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_read_req", 32'(avl_read_req), 32'd0);
    chk("abort_running", 32'(running), 32'd0);
    chk("abort_index", 32'(tbl_index), 32'd0);
    reset = 1'b0;
    busy_target = busy_spent;
    repeat (2) @(negedge clock);

    // start held high gives exactly one run
    set_all_write();
    b_run = run_rise;
    start_run(1'b1);
    wait_fin("held_fin", 100);
    repeat (20) @(negedge clock);
    chk("held_one_run", 32'(run_rise - b_run), 32'd1);
    chk("held_done", 32'(done), 32'd1);
    start = 1'b0;
    repeat (3) @(negedge clock);

    chk("never_both_reqs", 32'(both_high), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
